// File: rtl/bus_fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the bus_fifo write-side arbiter.
package bus_fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Index width that stays at least one bit wide for degenerate counts.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_burst);
        return idx_width(max_burst + 1);
    endfunction

endpackage

// File: rtl/bus_fifo_wr_arbiter_if.sv
// Requester/FIFO-write bundle; master is the requester+FIFO side, slave is the arbiter.
interface bus_fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8
);
    import bus_fifo_arb_pkg::*;

    localparam int unsigned OW = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]       REQ;
    logic [NUM_REQ*WIDTH-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]       REQ_LAST;
    logic [NUM_REQ-1:0]       GNT;
    logic [OW-1:0]            OWNER;
    logic                     BUSY;
    logic                     FIFO_STROBE;
    logic [WIDTH-1:0]         FIFO_DATA;
    logic                     FIFO_FULL;

    modport master (
        output REQ, REQ_DATA, REQ_LAST, FIFO_FULL,
        input  GNT, OWNER, BUSY, FIFO_STROBE, FIFO_DATA
    );

    modport slave (
        input  REQ, REQ_DATA, REQ_LAST, FIFO_FULL,
        output GNT, OWNER, BUSY, FIFO_STROBE, FIFO_DATA
    );

endinterface

// File: rtl/bus_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping.
module rr_pick
    import bus_fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [2*NUM_REQ-1:0] w_rot;
    logic [31:0]          w_off;
    logic [31:0]          w_pos;

    // Rotating a doubled copy puts the pointer position at bit 0.
    always_comb begin
        w_rot = {i_req, i_req} >> i_ptr;
        o_any = 1'b0;
        w_off = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!o_any && w_rot[k]) begin
                o_any = 1'b1;
                w_off = k;
            end
        end
        w_pos = 32'(i_ptr) + w_off;
        if (w_pos >= NUM_REQ) begin
            w_pos = w_pos - NUM_REQ;
        end
        o_idx    = IDX_W'(w_pos);
        o_onehot = o_any ? (NUM_REQ'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/bus_fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one bus_fifo write port among NUM_REQ requesters.
module bus_fifo_wr_arbiter
    import bus_fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    bus_fifo_wr_arbiter_if.slave  bus
);

    localparam int unsigned OW = idx_width(NUM_REQ);
    localparam int unsigned CW = cnt_width(MAX_BURST);

    arb_state_t         r_state;
    logic [OW-1:0]      r_ptr;
    logic [OW-1:0]      r_owner;
    logic [CW-1:0]      r_beat;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_busy;

    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [OW-1:0]      w_pick_idx;
    logic               w_pick_any;
    logic               w_owner_req;
    logic               w_owner_last;
    logic               w_xfer;
    logic               w_cap;
    logic               w_end;
    logic [OW-1:0]      w_next_ptr;
    logic [WIDTH-1:0]   w_slices [NUM_REQ];

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req    (bus.REQ),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign w_slices[g] = bus.REQ_DATA[g*WIDTH +: WIDTH];
    end

    assign w_owner_req  = bus.REQ[r_owner];
    assign w_owner_last = bus.REQ_LAST[r_owner];
    assign w_xfer       = (r_state == BURST) && w_owner_req && !bus.FIFO_FULL;
    assign w_cap        = (r_beat == CW'(MAX_BURST - 1));
    // Withdrawal ends the burst with no beat; cap and LAST only end it on a beat.
    assign w_end        = (r_state == BURST) &&
                          (!w_owner_req || (w_xfer && (w_owner_last || w_cap)));
    assign w_next_ptr   = (r_owner == OW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_beat  <= '0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_gnt   <= w_pick_onehot;
                        r_owner <= w_pick_idx;
                        r_busy  <= 1'b1;
                        r_beat  <= '0;
                        r_state <= BURST;
                    end
                end
                BURST: begin
                    if (w_end) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_next_ptr;
                        r_state <= IDLE;
                    end else if (w_xfer) begin
                        r_beat  <= r_beat + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.GNT         = r_gnt;
    assign bus.OWNER       = r_owner;
    assign bus.BUSY        = r_busy;
    assign bus.FIFO_STROBE = w_xfer;
    assign bus.FIFO_DATA   = r_busy ? w_slices[r_owner] : '0;

endmodule
